// File: rtl/i2c_slv_pkg.sv
// Shared types for the I2C target bank: FSM state encoding, bus event
// classification and a few protocol constants used by the bit counter.
package i2c_slv_pkg;

    // Transaction FSM states of the target bank.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } slv_state_t;

    // Bus conditions seen while SCL is held high.
    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_STOP  = 2'd2
    } bus_ev_t;

    localparam int BIT_CNT_W = 4;

    // Bit counter values inside a 9-clock byte frame:
    // LAST_DATA_BIT is the count before the 8th SCL rise,
    // ACK_WAIT is held between the 8th rise and the ACK-slot SCL rise,
    // ACK_HELD is held between the ACK-slot rise and the SCL fall ending it.
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = 4'd7;
    localparam logic [BIT_CNT_W-1:0] ACK_WAIT      = 4'd8;
    localparam logic [BIT_CNT_W-1:0] ACK_HELD      = 4'd9;

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA and classifies SCL edges plus START/STOP
// conditions on the synchronised values. Both lines pass the same number
// of flops, so their relative timing is preserved.
module i2c_bus_sync
    import i2c_slv_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    scl_i,
    input  logic    sda_i,
    output logic    sda_o,
    output logic    scl_rise_o,
    output logic    scl_fall_o,
    output bus_ev_t bus_ev_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchroniser chains and one-cycle history; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q[0] <= scl_i;
            sda_sync_q[0] <= sda_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_q[i] <= scl_sync_q[i-1];
                sda_sync_q[i] <= sda_sync_q[i-1];
            end
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;

    // START/STOP need SCL high in both the previous and current sample.
    always_comb begin
        bus_ev_o = EV_NONE;
        if (scl_s && scl_prev_q) begin
            if (sda_prev_q && !sda_s) begin
                bus_ev_o = EV_START;
            end else if (!sda_prev_q && sda_s) begin
                bus_ev_o = EV_STOP;
            end
        end
    end

endmodule

// File: rtl/i2c_slv_bank.sv
// Bank of NUM_CH I2C targets at consecutive 7-bit addresses sharing one
// register pointer. Writes are reported on a pulse interface, reads fetch
// bytes from the host through a request/response interface.
//
// Host-side interfaces are single-cycle pulses with no back-pressure:
// slv_rd_req is high for exactly one cycle with slv_rd_ch/slv_rd_ptr valid in
// that same cycle, and the host must present slv_rd_data in the cycle that
// follows; rpt_wr_vld is high for exactly one cycle with rpt_wr_ch/ptr/data
// valid in that cycle and must be consumed then.
module i2c_slv_bank
    import i2c_slv_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter logic [6:0] BASE_ADDR   = 7'h50,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i2c_scl_i,
    input  logic             i2c_sda_i,
    output logic             i2c_sda_oe,
    output logic             slv_rd_req,
    output logic [CH_W-1:0]  slv_rd_ch,
    output logic [PTR_W-1:0] slv_rd_ptr,
    input  logic [7:0]       slv_rd_data,
    output logic             rpt_wr_vld,
    output logic [CH_W-1:0]  rpt_wr_ch,
    output logic [PTR_W-1:0] rpt_wr_ptr,
    output logic [7:0]       rpt_wr_data,
    output logic             rpt_busy,
    output logic [7:0]       rpt_nack_cnt,
    output slv_state_t       dbg_state_o
);

    // Synchronised bus view
    logic    sda_s;
    logic    scl_rise;
    logic    scl_fall;
    bus_ev_t bus_ev;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (i2c_scl_i),
        .sda_i      (i2c_sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .bus_ev_o   (bus_ev)
    );

    // State registers and next-state values
    slv_state_t             state_q,    state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [7:0]             shreg_q,    shreg_d;
    logic [CH_W-1:0]        ch_q,       ch_d;
    logic [PTR_W-1:0]       ptr_q,      ptr_d;
    logic                   rw_q,       rw_d;
    logic                   oe_q,       oe_d;
    logic                   rd_req_q,   rd_req_d;
    logic [CH_W-1:0]        rd_ch_q,    rd_ch_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic                   rd_lat_q,   rd_lat_d;
    logic                   wr_vld_q,   wr_vld_d;
    logic [CH_W-1:0]        wr_ch_q,    wr_ch_d;
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [7:0]             wr_data_q,  wr_data_d;
    logic                   busy_q,     busy_d;
    logic [7:0]             nack_cnt_q, nack_cnt_d;

    // Byte as it stands after shifting in the bit sampled on this SCL rise.
    logic [7:0] byte_in;
    logic [7:0] addr_off;
    logic       addr_hit;
    logic       is_ack_st;

    assign byte_in   = {shreg_q[6:0], sda_s};
    assign addr_off  = {1'b0, byte_in[7:1]} - {1'b0, BASE_ADDR};
    assign addr_hit  = (byte_in[7:1] >= BASE_ADDR) && (addr_off < 8'(NUM_CH));
    assign is_ack_st = (state_q == ST_ADDR_ACK) || (state_q == ST_PTR_ACK) ||
                       (state_q == ST_WR_ACK);

    // Next-state logic: bus events first, then per-state bit handling.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ch_d       = ch_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        rd_req_d   = 1'b0;
        rd_ch_d    = rd_ch_q;
        rd_ptr_d   = rd_ptr_q;
        rd_lat_d   = rd_req_q;
        wr_vld_d   = 1'b0;
        wr_ch_d    = wr_ch_q;
        wr_ptr_d   = wr_ptr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        nack_cnt_d = nack_cnt_q;

        // Host byte arrives the cycle after the request; the pointer moves
        // on once the byte is captured. SCL cannot edge in this window.
        if (rd_lat_q) begin
            shreg_d = slv_rd_data;
            ptr_d   = ptr_q + PTR_W'(1);
        end

        if (bus_ev == EV_START) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (bus_ev == EV_STOP) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            ptr_d     = '0;
        end else if (is_ack_st) begin
            // Drive ACK from the fall after the 8th bit to the fall after the 9th.
            if (scl_fall && bit_cnt_q == ACK_WAIT) begin
                oe_d = 1'b1;
            end else if (scl_rise) begin
                bit_cnt_d = ACK_HELD;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                    rd_req_d = 1'b1;
                    rd_ch_d  = ch_q;
                    rd_ptr_d = ptr_q;
                end
            end else if (scl_fall && bit_cnt_q == ACK_HELD) begin
                bit_cnt_d = '0;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                    oe_d    = ~shreg_q[7];
                    state_d = ST_RD_DATA;
                end else begin
                    oe_d    = 1'b0;
                    state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WR_DATA;
                end
            end
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            if (addr_hit) begin
                                ch_d    = addr_off[CH_W-1:0];
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            ptr_d   = byte_in[PTR_W-1:0];
                            state_d = ST_PTR_ACK;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            wr_vld_d  = 1'b1;
                            wr_ch_d   = ch_q;
                            wr_ptr_d  = ptr_q;
                            wr_data_d = byte_in;
                            ptr_d     = ptr_q + PTR_W'(1);
                            state_d   = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Master samples on rise; next bit goes out on the fall.
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            state_d = ST_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        oe_d    = ~shreg_q[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall && bit_cnt_q == ACK_WAIT) begin
                        oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_s) begin
                            nack_cnt_d = sat_inc8(nack_cnt_q);
                            bit_cnt_d  = '0;
                            state_d    = ST_IGNORE;
                        end else begin
                            rd_req_d  = 1'b1;
                            rd_ch_d   = ch_q;
                            rd_ptr_d  = ptr_q;
                            bit_cnt_d = ACK_HELD;
                        end
                    end else if (scl_fall && bit_cnt_q == ACK_HELD) begin
                        oe_d      = ~shreg_q[7];
                        bit_cnt_d = '0;
                        state_d   = ST_RD_DATA;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ch_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_ch_q    <= '0;
            rd_ptr_q   <= '0;
            rd_lat_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_ch_q    <= '0;
            wr_ptr_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            nack_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ch_q       <= ch_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            rd_req_q   <= rd_req_d;
            rd_ch_q    <= rd_ch_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_lat_q   <= rd_lat_d;
            wr_vld_q   <= wr_vld_d;
            wr_ch_q    <= wr_ch_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            nack_cnt_q <= nack_cnt_d;
        end
    end

    assign i2c_sda_oe   = oe_q;
    assign slv_rd_req   = rd_req_q;
    assign slv_rd_ch    = rd_ch_q;
    assign slv_rd_ptr   = rd_ptr_q;
    assign rpt_wr_vld   = wr_vld_q;
    assign rpt_wr_ch    = wr_ch_q;
    assign rpt_wr_ptr   = wr_ptr_q;
    assign rpt_wr_data  = wr_data_q;
    assign rpt_busy     = busy_q;
    assign rpt_nack_cnt = nack_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_i2c_slv_bank.sv
// Bench for i2c_slv_bank: bit-banged I2C master, host read responder,
// reference model of the register pointer, scoreboard queues for write
// reports and read requests, and a final summary.
`timescale 1ns/1ps
module tb_i2c_slv_bank;
  import i2c_slv_pkg::*;

  localparam int         NUM_CH = 2;
  localparam logic [6:0] BASE   = 7'h50;
  localparam int         PTR_W  = 4;
  localparam int         SYNC   = 2;
  localparam int         CH_W   = 1;
  localparam int         DEPTH  = 1 << PTR_W;
  localparam int         WRW    = CH_W + PTR_W + 8;
  localparam int         RQW    = CH_W + PTR_W;
  localparam int         Q      = 6;
  localparam int         H      = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             m_scl = 1'b1;
  logic             m_sda = 1'b1;
  logic             sda_line;
  logic             i2c_sda_oe;
  logic             slv_rd_req;
  logic [CH_W-1:0]  slv_rd_ch;
  logic [PTR_W-1:0] slv_rd_ptr;
  logic [7:0]       slv_rd_data = 8'h00;
  logic             rpt_wr_vld;
  logic [CH_W-1:0]  rpt_wr_ch;
  logic [PTR_W-1:0] rpt_wr_ptr;
  logic [7:0]       rpt_wr_data;
  logic             rpt_busy;
  logic [7:0]       rpt_nack_cnt;
  slv_state_t       dbg_state;

  // open-drain wired SDA
  assign sda_line = m_sda & ~i2c_sda_oe;

  i2c_slv_bank #(
    .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .PTR_W(PTR_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst),
    .i2c_scl_i(m_scl), .i2c_sda_i(sda_line), .i2c_sda_oe(i2c_sda_oe),
    .slv_rd_req(slv_rd_req), .slv_rd_ch(slv_rd_ch), .slv_rd_ptr(slv_rd_ptr),
    .slv_rd_data(slv_rd_data),
    .rpt_wr_vld(rpt_wr_vld), .rpt_wr_ch(rpt_wr_ch), .rpt_wr_ptr(rpt_wr_ptr),
    .rpt_wr_data(rpt_wr_data), .rpt_busy(rpt_busy), .rpt_nack_cnt(rpt_nack_cnt),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  int m_nack = 0;
  logic oe_seen = 1'b0;
  logic [WRW-1:0] exp_wr_q[$];
  logic [RQW-1:0] exp_rq_q[$];
  logic [7:0] tx_buf[8];

  function automatic logic [7:0] rd_fn(input int ch, input int p);
    return 8'((p * 17 + ch * 64) & 255);
  endfunction

  function automatic bit addr_hit(input logic [6:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + NUM_CH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // host memory: answers a read request with data in the following cycle
  always @(posedge clk) begin
    if (slv_rd_req) slv_rd_data <= rd_fn(int'(slv_rd_ch), int'(slv_rd_ptr));
  end

  // monitor: pop and compare whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (i2c_sda_oe) oe_seen = 1'b1;
      if (rpt_wr_vld) begin
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_report_unexpected got=%0h required=none", {rpt_wr_ch, rpt_wr_ptr, rpt_wr_data});
        end else begin
          chk("wr_report", 32'({rpt_wr_ch, rpt_wr_ptr, rpt_wr_data}), 32'(exp_wr_q.pop_front()));
        end
      end
      if (slv_rd_req) begin
        if (exp_rq_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_req_unexpected got=%0h required=none", {slv_rd_ch, slv_rd_ptr});
        end else begin
          chk("rd_req", 32'({slv_rd_ch, slv_rd_ptr}), 32'(exp_rq_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(H);
    m_sda = 1'b0; wait_clk(H);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(H);
    m_sda = 1'b1; wait_clk(H);
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1; wait_clk(H);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(H / 2);
    b = sda_line; wait_clk(H / 2);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
    wr_bit(nack);
  endtask

  // write: tx_buf[0] is the pointer byte, tx_buf[1..n-1] the data bytes
  task automatic txn_write(input logic [6:0] a, input int n, input bit do_stop);
    logic ack;
    int ch;
    bit h;
    h = addr_hit(a);
    ch = int'(a) - int'(BASE);
    oe_seen = 1'b0;
    bus_start();
    wr_byte({a, 1'b0}, ack);
    chk("wr_addr_ack", 32'(ack), h ? 32'd0 : 32'd1);
    chk("busy_after_addr", 32'(rpt_busy), h ? 32'd1 : 32'd0);
    for (int i = 0; i < n; i++) begin
      if (h) begin
        if (i == 0) begin
          m_ptr = int'(tx_buf[0]) % DEPTH;
        end else begin
          exp_wr_q.push_back({CH_W'(ch), PTR_W'(m_ptr), tx_buf[i]});
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
      wr_byte(tx_buf[i], ack);
      chk("wr_byte_ack", 32'(ack), h ? 32'd0 : 32'd1);
    end
    if (!h) chk("no_oe_unaddressed", 32'(oe_seen), 32'd0);
    if (do_stop) begin
      bus_stop();
      m_ptr = 0;
      chk("busy_after_stop", 32'(rpt_busy), 32'd0);
    end
  endtask

  // (repeated) START, read n bytes NACKing the last, then STOP
  task automatic txn_read(input logic [6:0] a, input int n);
    logic ack;
    logic [7:0] v;
    logic [7:0] exp_b[4];
    int ch;
    bit h;
    h = addr_hit(a);
    ch = int'(a) - int'(BASE);
    oe_seen = 1'b0;
    if (h) begin
      for (int i = 0; i < n; i++) begin
        exp_rq_q.push_back({CH_W'(ch), PTR_W'(m_ptr)});
        exp_b[i] = rd_fn(ch, m_ptr);
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    bus_start();
    wr_byte({a, 1'b1}, ack);
    chk("rd_addr_ack", 32'(ack), h ? 32'd0 : 32'd1);
    if (h) begin
      for (int i = 0; i < n; i++) begin
        rd_byte((i == n - 1) ? 1'b1 : 1'b0, v);
        chk("rd_byte", 32'(v), 32'(exp_b[i]));
      end
      if (m_nack < 255) m_nack++;
    end else begin
      chk("no_oe_unaddressed_rd", 32'(oe_seen), 32'd0);
    end
    chk("nack_cnt", 32'(rpt_nack_cnt), 32'(m_nack));
    bus_stop();
    m_ptr = 0;
    chk("busy_after_rd_stop", 32'(rpt_busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ack;
    logic [6:0] a;
    int sel;
    int n;

    wait_clk(4);
    chk("rst_oe", 32'(i2c_sda_oe), 32'd0);
    chk("rst_rd_req", 32'(slv_rd_req), 32'd0);
    chk("rst_wr_vld", 32'(rpt_wr_vld), 32'd0);
    chk("rst_busy", 32'(rpt_busy), 32'd0);
    chk("rst_nack", 32'(rpt_nack_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    wait_clk(H);

    // write to channel 1: pointer 3, two data bytes
    tx_buf[0] = 8'h03; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h5A;
    txn_write(7'h51, 3, 1'b1);

    // address outside the bank
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h77;
    txn_write(7'h52, 2, 1'b1);

    // pointer 0x0F, repeated START, read two bytes with wrap
    tx_buf[0] = 8'h0F;
    txn_write(7'h50, 1, 1'b0);
    txn_read(7'h50, 2);

    // write wrap from 0x0E
    tx_buf[0] = 8'h0E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    txn_write(7'h50, 4, 1'b1);

    // STOP after four data bits
    bus_start();
    wr_byte({7'h50, 1'b0}, ack);
    chk("partial_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'h07, ack);
    chk("partial_ptr_ack", 32'(ack), 32'd0);
    chk("partial_busy", 32'(rpt_busy), 32'd1);
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b1);
    bus_stop();
    m_ptr = 0;
    chk("partial_busy_fall", 32'(rpt_busy), 32'd0);
    chk("partial_state", 32'(dbg_state), 32'(ST_IDLE));

    // reset during a read bit while SDA is driven low (byte 0x00)
    exp_rq_q.push_back({CH_W'(0), PTR_W'(0)});
    bus_start();
    wr_byte({7'h50, 1'b1}, ack);
    chk("rst_rd_addr_ack", 32'(ack), 32'd0);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(3);
    chk("oe_before_rst", 32'(i2c_sda_oe), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("oe_after_rst", 32'(i2c_sda_oe), 32'd0);
    chk("nack_after_rst", 32'(rpt_nack_cnt), 32'd0);
    m_ptr = 0;
    m_nack = 0;
    wait_clk(H);
    m_scl = 1'b0; wait_clk(Q);
    bus_stop();
    chk("state_after_rst", 32'(dbg_state), 32'(ST_IDLE));
    tx_buf[0] = 8'h05; tx_buf[1] = 8'hC3;
    txn_write(7'h50, 2, 1'b0);
    txn_read(7'h50, 1);

    // randomized transactions
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 3);
      if (sel == 3) a = 7'($urandom_range(0, 127));
      else          a = 7'(int'(BASE) + $urandom_range(0, NUM_CH));
      for (int i = 0; i < 8; i++) tx_buf[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 4);
        txn_write(a, n, 1'b1);
      end else begin
        txn_write(a, 1, 1'b0);
        n = $urandom_range(1, 3);
        txn_read(a, n);
      end
    end

    wait_clk(H);
    chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    chk("rq_queue_empty", 32'(exp_rq_q.size()), 32'd0);
    chk("final_oe", 32'(i2c_sda_oe), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slv_bank.md
I2C_SLV_BANK -- requirements
Module: i2c_slv_bank

Interface
REQ-001 Parameter NUM_CH, default 2: number of I2C targets served (1..8).
REQ-002 Parameter BASE_ADDR, default 7'h50: 7-bit address of channel 0; channel k answers BASE_ADDR+k.
REQ-003 Parameter PTR_W, default 4: register-pointer width; each channel has 2^PTR_W byte locations.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth on SCL/SDA inputs.
REQ-005 Localparam CH_W = max(1, clog2(NUM_CH)).
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock; all state on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 i2c_scl_i  in  1  raw SCL, asynchronous.
REQ-010 i2c_sda_i  in  1  raw SDA, asynchronous.
REQ-011 i2c_sda_oe  out  1  1 = pull SDA low (open drain).
REQ-012 slv_rd_req  out  1  one-cycle read request.
REQ-013 slv_rd_ch / slv_rd_ptr  out  CH_W / PTR_W  target of slv_rd_req.
REQ-014 slv_rd_data  in  8  read byte, valid the cycle after slv_rd_req.
REQ-015 rpt_wr_vld  out  1  one-cycle write report.
REQ-016 rpt_wr_ch / rpt_wr_ptr / rpt_wr_data  out  CH_W / PTR_W / 8  written location and byte.
REQ-017 rpt_busy  out  1  high from addressed ACK until STOP or START.
REQ-018 rpt_nack_cnt  out  8  count of master NACKs ending reads, saturating at 255.

Function
REQ-019 Inputs SHALL pass SYNC_STAGES flops; edges and START (SDA fall, SCL high) / STOP (SDA rise, SCL high) SHALL be detected on synchronised values.
REQ-020 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-021 START from any state SHALL enter ADDR with bit counter cleared (repeated START included); STOP from any state SHALL enter IDLE.
REQ-022 ADDR samples 8 bits MSB-first on SCL rise; address outside BASE_ADDR..BASE_ADDR+NUM_CH-1 SHALL go to IGNORE with SDA released.
REQ-023 Matching address SHALL latch channel, assert i2c_sda_oe from the following SCL fall through the next SCL fall (ADDR_ACK), then go to PTR (R/W=0) or RD_DATA (R/W=1).
REQ-024 PTR byte SHALL be ACKed and load pointer from its low PTR_W bits; subsequent bytes go WR_DATA/WR_ACK.
REQ-025 Each WR_DATA byte SHALL be ACKed; rpt_wr_vld SHALL pulse one cycle after the 8th-bit SCL rise with current pointer; pointer then increments.
REQ-026 slv_rd_req SHALL pulse on the SCL rise of the ADDR_ACK bit (read) and of each RD_ACK bit where master ACKs; byte latched next cycle, shifted MSB-first, SDA changed only on SCL fall.
REQ-027 RD_DATA drives oe = ~bit; pointer increments after each byte; master NACK in RD_ACK SHALL go to IGNORE and increment rpt_nack_cnt.
REQ-028 Pointer SHALL wrap 2^PTR_W-1 -> 0; it persists per transaction only (channel-shared register).
REQ-029 START and STOP detected in same cycle as an SCL edge SHALL take priority over bit sampling.
REQ-030 SCL high/low phases shorter than SYNC_STAGES+3 clk are outside specification.

Reset
REQ-031 rst SHALL force IDLE, i2c_sda_oe=0, slv_rd_req=0, rpt_wr_vld=0, rpt_busy=0, rpt_nack_cnt=0, pointer=0, synchronisers to 1; reset mid-transfer SHALL release SDA next cycle and ignore bus until next START.

Structure
REQ-032 FSM state enum and START/STOP edge-type typedef SHALL live in shared package i2c_slv_pkg.
REQ-033 Synchroniser plus edge/START/STOP detection SHALL be one sub-module i2c_bus_sync.

Verification
REQ-034 NUM_CH=2: write addr 0x51, ptr 0x03, data 0xA5,0x5A -> ACK all; rpt_wr (1,3,0xA5) then (1,4,0x5A).
REQ-035 Addr 0x52 -> no ACK, oe stays 0, no reports, busy 0.
REQ-036 Write ptr 0x0F to 0x50, repeated START, read 2 bytes (slv_rd_data=ptr*0x11), NACK last -> bytes 0xFF, 0x00; nack_cnt=1.
REQ-037 PTR_W=4, write 3 bytes from ptr 0x0E -> reports at ptrs 0x0E, 0x0F, 0x00.
REQ-038 rst asserted mid read bit -> oe 0 next cycle; following transaction to 0x50 behaves normally.
REQ-039 STOP after 4 data bits -> IDLE, no rpt_wr_vld, busy falls.
